// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS symbol word-alignment (bitslip search/lock) and 10b->8b decode.
//   clock        single clock, at most one symbol per cycle
//   reset        asynchronous, active-high
//   io_tmds      raw deserialized symbol, q[0] transmitted first
//   io_valid     io_tmds valid this cycle
//   io_bitslip   one-cycle request to shift the deserializer word boundary
//   io_slipCount slips issued, modulo 10
//   io_locked    symbol alignment acquired
//   io_outValid  decoded outputs updated this cycle (io_valid delayed by one)
//   io_de        decoded symbol was video data
//   io_data      decoded video byte
//   io_ctrl      decoded control bits {c1,c0}
module tmds_decoder #(
    parameter int SEARCH_WINDOW = 2048,
    parameter int SETTLE        = 16,
    parameter int LOCK_RUN      = 8,
    parameter int LOSS_WINDOW   = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] io_tmds,
    input  logic       io_valid,
    output logic       io_bitslip,
    output logic [3:0] io_slipCount,
    output logic       io_locked,
    output logic       io_outValid,
    output logic       io_de,
    output logic [7:0] io_data,
    output logic [1:0] io_ctrl
);
    localparam int WW = $clog2(SEARCH_WINDOW + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int RW = $clog2(LOCK_RUN + 1);
    localparam int LW = $clog2(LOSS_WINDOW + 1);
    // Counters compare against value-1 so the expiring symbol acts on the same edge.
    localparam logic [WW-1:0] WIN_LAST    = WW'(SEARCH_WINDOW - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [RW-1:0] RUN_LAST    = RW'(LOCK_RUN - 1);
    localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_WINDOW - 1);

    typedef enum logic [1:0] {S_SEARCH, S_SETTLE, S_LOCKED} state_t;

    state_t        state;
    logic [WW-1:0] win_cnt;
    logic [SW-1:0] settle_cnt;
    logic [RW-1:0] run_cnt;
    logic [LW-1:0] loss_cnt;
    logic          c0, c1, c2, c3, is_ctrl;
    logic [1:0]    ctrl_dec;
    logic [7:0]    d, data_dec;

    assign c0       = io_tmds == 10'b1101010100;
    assign c1       = io_tmds == 10'b0010101011;
    assign c2       = io_tmds == 10'b0101010100;
    assign c3       = io_tmds == 10'b1010101011;
    assign is_ctrl  = c0 | c1 | c2 | c3;
    assign ctrl_dec = {c2 | c3, c1 | c3};
    assign d        = io_tmds[9] ? ~io_tmds[7:0] : io_tmds[7:0];

    // q[8] selects XOR vs XNOR transition coding between adjacent bits.
    always_comb begin
        data_dec[0] = d[0];
        for (int i = 1; i < 8; i++)
            data_dec[i] = io_tmds[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_SEARCH;
            win_cnt      <= '0;
            settle_cnt   <= '0;
            run_cnt      <= '0;
            loss_cnt     <= '0;
            io_bitslip   <= 1'b0;
            io_slipCount <= 4'd0;
            io_locked    <= 1'b0;
            io_outValid  <= 1'b0;
            io_de        <= 1'b0;
            io_data      <= 8'h00;
            io_ctrl      <= 2'b00;
        end else begin
            io_bitslip  <= 1'b0;
            io_outValid <= io_valid;
            if (io_valid) begin
                case (state)
                    S_SEARCH: begin
                        io_de   <= 1'b0;
                        io_data <= 8'h00;
                        io_ctrl <= 2'b00;
                        // Lock is tested first so it wins over a coincident window expiry.
                        if (is_ctrl && run_cnt == RUN_LAST) begin
                            state     <= S_LOCKED;
                            io_locked <= 1'b1;
                            io_ctrl   <= ctrl_dec;
                            win_cnt   <= '0;
                            run_cnt   <= '0;
                            loss_cnt  <= '0;
                        end else if (!is_ctrl && win_cnt == WIN_LAST) begin
                            state        <= S_SETTLE;
                            io_bitslip   <= 1'b1;
                            io_slipCount <= io_slipCount == 4'd9 ? 4'd0 : io_slipCount + 4'd1;
                            win_cnt      <= '0;
                            run_cnt      <= '0;
                            settle_cnt   <= '0;
                        end else begin
                            win_cnt <= is_ctrl ? '0 : win_cnt + 1'b1;
                            run_cnt <= is_ctrl ? run_cnt + 1'b1 : '0;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= S_SEARCH;
                            settle_cnt <= '0;
                            win_cnt    <= '0;
                            run_cnt    <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (is_ctrl) begin
                            io_de    <= 1'b0;
                            io_data  <= 8'h00;
                            io_ctrl  <= ctrl_dec;
                            loss_cnt <= '0;
                        end else if (loss_cnt == LOSS_LAST) begin
                            state     <= S_SEARCH;
                            io_locked <= 1'b0;
                            io_de     <= 1'b0;
                            io_data   <= 8'h00;
                            io_ctrl   <= 2'b00;
                            loss_cnt  <= '0;
                            win_cnt   <= '0;
                            run_cnt   <= '0;
                        end else begin
                            io_de    <= 1'b1;
                            io_data  <= data_dec;
                            loss_cnt <= loss_cnt + 1'b1;
                        end
                    end
                    default: state <= S_SEARCH;
                endcase
            end
        end
    end
endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter SEARCH_WINDOW, default 2048: valid symbols without any control symbol before a bitslip is requested.
REQ-002 SHALL have parameter SETTLE, default 16: valid symbols ignored after a bitslip.
REQ-003 SHALL have parameter LOCK_RUN, default 8: consecutive control symbols required for lock.
REQ-004 SHALL have parameter LOSS_WINDOW, default 4096: valid symbols without any control symbol that drop lock.
REQ-005 SHALL have port clock, input, 1: single clock for all logic, one symbol per clock at most.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port io_tmds, input, 10: raw deserialized symbol q[9:0], with q[0] transmitted first.
REQ-008 SHALL have port io_valid, input, 1: io_tmds is valid this cycle.
REQ-009 SHALL have port io_bitslip, output, 1: one-cycle request to the deserializer to shift the word boundary by one bit.
REQ-010 SHALL have port io_slipCount, output, 4: number of slips issued, modulo 10.
REQ-011 SHALL have port io_locked, output, 1: symbol alignment acquired.
REQ-012 SHALL have port io_outValid, output, 1: decoded outputs updated this cycle.
REQ-013 SHALL have port io_de, output, 1: decoded symbol was a video-data symbol.
REQ-014 SHALL have port io_data, output, 8: decoded video byte.
REQ-015 SHALL have port io_ctrl, output, 2: decoded control bits {c1,c0}.

Function
REQ-016 SHALL classify control symbols exactly as follows: 10'b1101010100 gives ctrl 00; 10'b0010101011 gives 01; 10'b0101010100 gives 10; 10'b1010101011 gives 11. Every other word SHALL be classified as video.
REQ-017 SHALL decode video symbols in two steps: first d = q[9] ? ~q[7:0] : q[7:0]; then out[0]=d[0] and, for i=1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-018 SHALL register decoded outputs with a latency of 1 clock: io_outValid is io_valid delayed one cycle, and the outputs update only on valid symbols.
REQ-019 SHALL hold all outputs and all state/counters unchanged on cycles where io_valid=0, except io_bitslip and io_outValid, which SHALL be 0 on those cycles.
REQ-020 SHALL implement an FSM with states SEARCH, SETTLE, LOCKED.
REQ-021 In SEARCH, a window counter SHALL count valid symbols and clear on each control symbol. A run counter SHALL count consecutive control symbols and clear on each video symbol.
REQ-022 In SEARCH, when the run counter reaches LOCK_RUN, the FSM SHALL go to LOCKED on that edge. That LOCK_RUN-th symbol SHALL be the first presented with io_de=0 and its decoded io_ctrl.
REQ-023 In SEARCH, when the window counter reaches SEARCH_WINDOW, the FSM SHALL pulse io_bitslip for one cycle, increment io_slipCount (9 wraps to 0), and go to SETTLE.
REQ-024 If lock and window expiry coincide on the same symbol, lock SHALL take priority and no bitslip SHALL be issued.
REQ-025 In SETTLE, the FSM SHALL count SETTLE valid symbols without evaluating them, then enter SEARCH with all counters cleared.
REQ-026 In LOCKED, a control symbol SHALL give io_de=0, io_data=0, io_ctrl=decoded.
REQ-027 In LOCKED, a video symbol SHALL give io_de=1, io_data=decoded, and io_ctrl holding its previous value.
REQ-028 In LOCKED, a loss counter SHALL count valid symbols since the last control symbol. When it reaches LOSS_WINDOW, the FSM SHALL drop io_locked and enter SEARCH with counters cleared, without issuing a bitslip.
REQ-029 When not LOCKED, io_de, io_data and io_ctrl SHALL be 0 (io_outValid still follows io_valid).
REQ-030 Counters SHALL be sized to hold their parameter value and SHALL never wrap within a state.

Reset
REQ-031 While reset is high, the block SHALL asynchronously force the state to SEARCH, all counters to 0, and every output to 0 (io_bitslip, io_slipCount, io_locked, io_outValid, io_de, io_data, io_ctrl).
REQ-032 Reset asserted mid-operation in any state SHALL abort the operation immediately. After release, operation SHALL resume in SEARCH with no pending bitslip.

Verification
REQ-033 Reset: assert reset for 3 cycles during LOCKED -> all outputs 0 asynchronously; after release the block is in SEARCH with io_slipCount=0.
REQ-034 Lock and decode: 8 valid 10'b1101010100 -> io_locked=1 on the 8th symbol's edge, io_ctrl=00. Then 10'h100 -> io_de=1, io_data=8'h00. Then 10'h200 -> io_data=8'hFF, io_ctrl still 00.
REQ-035 Misalignment: 2048 valid 10'h155 (never a control word) -> exactly one io_bitslip pulse, io_slipCount=1. A control run during the next 16 symbols does not lock.
REQ-036 Slip wrap: continuous non-control stream for 10 windows -> io_slipCount counts 1..9 then 0, with ten single-cycle pulses spaced 2048+16 valid symbols apart.
REQ-037 Loss of lock: after lock, 4096 valid video symbols -> io_locked falls on the 4096th, io_bitslip stays 0, outputs forced 0.
REQ-038 Valid gaps: interleave io_valid=0 cycles into the REQ-034 stream -> identical results, lock delayed only by the gap count, io_outValid low on each gap+1 cycle.
